// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared encodings and width helper for the convolution/gradient engine
// Contents: mode encodings, FSM state encoding, accumulator width helper.
package conv_pkg;

    localparam int N_MIN = 2;
    localparam int N_MAX = 7;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'b00,
        MODE_CLAMP  = 2'b01,
        MODE_TRANSP = 2'b10,
        MODE_EXPL   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FINAL = 2'b10,
        DONE  = 2'b11
    } state_e;

    // Wide enough that N*N full-scale products can never overflow.
    function automatic int acc_w(input int pix_w, input int coef_w, input int n);
        return pix_w + coef_w + $clog2(n * n) + 1;
    endfunction

endpackage

// File: rtl/conv_grad_engine_if.sv
// rtl/conv_grad_engine_if.sv - control/operand/result bundle of the convolution/gradient engine
// Signals: start, mode[1:0], window, kernel_a, kernel_b, shift[3:0] (master drives);
//          busy, done_o, result[3*OUT_W-1:0] = {mag, g2, g1} (slave drives).
interface conv_grad_engine_if #(
    parameter int N      = 5,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 8
);
    logic                      start;
    logic [1:0]                mode;
    logic [N*N*PIX_W-1:0]      window;
    logic [N*N*COEF_W-1:0]     kernel_a;
    logic [N*N*COEF_W-1:0]     kernel_b;
    logic [3:0]                shift;
    logic                      busy;
    logic                      done_o;
    logic [3*OUT_W-1:0]        result;

    modport master (
        output start, mode, window, kernel_a, kernel_b, shift,
        input  busy, done_o, result
    );

    modport slave (
        input  start, mode, window, kernel_a, kernel_b, shift,
        output busy, done_o, result
    );
endinterface

// File: rtl/conv_sat_abs.sv
// rtl/conv_sat_abs.sv - absolute value with optional negative clamp and unsigned saturation
// Ports: acc_i (signed ACC_W) in, clamp_i in (negative input -> 0), sat_o (unsigned OUT_W) out.
module conv_sat_abs #(
    parameter int ACC_W = 22,
    parameter int OUT_W = 8
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic                    clamp_i,
    output logic        [OUT_W-1:0] sat_o
);
    logic             neg;
    logic [ACC_W-1:0] mag;

    assign neg = acc_i[ACC_W-1];
    // The most negative ACC_W value is unreachable, so negation never wraps.
    assign mag = neg ? $unsigned(-acc_i) : $unsigned(acc_i);

    always_comb begin
        sat_o = mag[OUT_W-1:0];
        if (neg && clamp_i) begin
            sat_o = '0;
        end else if (|mag[ACC_W-1:OUT_W]) begin
            sat_o = '1;
        end
    end
endmodule

// File: rtl/conv_grad_engine.sv
// rtl/conv_grad_engine.sv - serial NxN convolution/gradient engine with saturated magnitude
// Ports: clk, reset (async, active high), bus (conv_grad_engine_if.slave).
// Optional: define NORM_SHIFT_EN to arithmetic-right-shift both accumulators by the latched shift.
module conv_grad_engine
    import conv_pkg::*;
#(
    parameter int N      = 5,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    conv_grad_engine_if.slave    bus
);
    localparam int NE     = N * N;
    localparam int ACC_W  = acc_w(PIX_W, COEF_W, N);
    localparam int IDX_W  = $clog2(NE);
    localparam int PROD_W = PIX_W + 1 + COEF_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NE - 1);

    state_e                    state_q;
    mode_e                     mode_q;
    logic                      start_q;
    logic                      busy_q;
    logic                      done_q;
    logic [3*OUT_W-1:0]        result_q;
    logic [IDX_W-1:0]          idx_q;
    logic [NE*PIX_W-1:0]       win_q;
    logic [NE*COEF_W-1:0]      ka_q;
    logic [NE*COEF_W-1:0]      kb_q;
    logic signed [ACC_W-1:0]   acc1_q;
    logic signed [ACC_W-1:0]   acc2_q;

    // Transposed copy of kernel_a: element (r,c) comes from (c,r).
    logic [NE*COEF_W-1:0] ka_t;
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign ka_t[(r*N+c)*COEF_W +: COEF_W] = bus.kernel_a[(c*N+r)*COEF_W +: COEF_W];
        end
    end

    // Second kernel chosen at launch; in single-kernel modes it only feeds an ignored accumulator.
    logic [NE*COEF_W-1:0] kb_sel;
    always_comb begin
        kb_sel = bus.kernel_a;
        if (bus.mode == MODE_EXPL) begin
            kb_sel = bus.kernel_b;
        end else if (bus.mode == MODE_TRANSP) begin
            kb_sel = ka_t;
        end
    end

    // One shared MAC per kernel, one element per cycle.
    logic        [PIX_W-1:0]  pix_cur;
    logic signed [PIX_W:0]    pix_s;
    logic signed [COEF_W-1:0] ka_cur;
    logic signed [COEF_W-1:0] kb_cur;
    logic signed [PROD_W-1:0] prod1;
    logic signed [PROD_W-1:0] prod2;

    assign pix_cur = win_q[idx_q*PIX_W +: PIX_W];
    assign ka_cur  = ka_q[idx_q*COEF_W +: COEF_W];
    assign kb_cur  = kb_q[idx_q*COEF_W +: COEF_W];
    assign pix_s   = {1'b0, pix_cur};
    assign prod1   = pix_s * ka_cur;
    assign prod2   = pix_s * kb_cur;

    logic signed [ACC_W-1:0] acc1_sh;
    logic signed [ACC_W-1:0] acc2_sh;

`ifdef NORM_SHIFT_EN
    logic [3:0] shift_q;
    assign acc1_sh = acc1_q >>> shift_q;
    assign acc2_sh = acc2_q >>> shift_q;
`else
    logic unused_shift;
    assign unused_shift = ^bus.shift;
    assign acc1_sh = acc1_q;
    assign acc2_sh = acc2_q;
`endif

    logic [OUT_W-1:0] g1;
    logic [OUT_W-1:0] g2_raw;

    conv_sat_abs #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat1 (
        .acc_i   (acc1_sh),
        .clamp_i (mode_q == MODE_CLAMP),
        .sat_o   (g1)
    );

    conv_sat_abs #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat2 (
        .acc_i   (acc2_sh),
        .clamp_i (1'b0),
        .sat_o   (g2_raw)
    );

    // Dual-kernel modes have mode bit 1 set.
    logic               dual;
    logic [OUT_W-1:0]   g2_d;
    logic [OUT_W:0]     sum_d;
    logic [OUT_W-1:0]   mag_d;
    logic [3*OUT_W-1:0] result_d;

    assign dual     = mode_q[1];
    assign g2_d     = dual ? g2_raw : '0;
    assign sum_d    = {1'b0, g1} + {1'b0, g2_d};
    assign mag_d    = !dual ? g1 : (sum_d[OUT_W] ? '1 : sum_d[OUT_W-1:0]);
    assign result_d = {mag_d, g2_d, g1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mode_q   <= MODE_SINGLE;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            idx_q    <= '0;
            win_q    <= '0;
            ka_q     <= '0;
            kb_q     <= '0;
            acc1_q   <= '0;
            acc2_q   <= '0;
`ifdef NORM_SHIFT_EN
            shift_q  <= '0;
`endif
        end else begin
            start_q <= bus.start;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !start_q) begin
                        win_q   <= bus.window;
                        ka_q    <= bus.kernel_a;
                        kb_q    <= kb_sel;
                        mode_q  <= mode_e'(bus.mode);
`ifdef NORM_SHIFT_EN
                        shift_q <= bus.shift;
`endif
                        acc1_q  <= '0;
                        acc2_q  <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc1_q <= acc1_q + ACC_W'(prod1);
                    acc2_q <= acc2_q + ACC_W'(prod2);
                    if (idx_q == LAST_IDX) begin
                        state_q <= FINAL;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                FINAL: begin
                    result_q <= result_d;
                    state_q  <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done_o = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_conv_grad_engine.sv
// tb/tb_conv_grad_engine.sv - self-checking bench for conv_grad_engine (N=3, 8-bit fields)
module tb_conv_grad_engine;
    localparam int N  = 3;
    localparam int NE = N * N;

    logic clk;
    logic reset;

    conv_grad_engine_if #(.N(N), .PIX_W(8), .COEF_W(8), .OUT_W(8)) bus ();

    conv_grad_engine #(.N(N), .PIX_W(8), .COEF_W(8), .OUT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;
    int pix [NE];
    int ka  [NE];
    int kb  [NE];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat255(input longint v);
        return (v > 255) ? 255 : v;
    endfunction

    // Reference: plain dot products, then the gradient rules on the results.
    function automatic logic [31:0] model(input int m, input int sh);
        longint a1, a2, g1, g2, mag;
        int k2, esh;
        a1 = 0;
        a2 = 0;
        esh = 0;
`ifdef NORM_SHIFT_EN
        esh = sh;
`endif
        for (int i = 0; i < NE; i++) begin
            if (m == 3)      k2 = kb[i];
            else if (m == 2) k2 = ka[(i % N) * N + (i / N)];
            else             k2 = 0;
            a1 += longint'(pix[i]) * ka[i];
            a2 += longint'(pix[i]) * k2;
        end
        a1 = a1 >>> esh;
        a2 = a2 >>> esh;
        if (a1 < 0) g1 = (m == 1) ? 0 : sat255(-a1);
        else        g1 = sat255(a1);
        g2  = (m >= 2) ? sat255(a2 < 0 ? -a2 : a2) : 0;
        mag = (m >= 2) ? sat255(g1 + g2) : g1;
        return {8'h00, mag[7:0], g2[7:0], g1[7:0]};
    endfunction

    task automatic drive_ops(input int m, input int sh);
        for (int i = 0; i < NE; i++) begin
            bus.window[i*8 +: 8]   = 8'(pix[i]);
            bus.kernel_a[i*8 +: 8] = 8'(ka[i]);
            bus.kernel_b[i*8 +: 8] = 8'(kb[i]);
        end
        bus.mode  = 2'(m);
        bus.shift = 4'(sh);
    endtask

    // Returns with time at launch edge + 1.
    task automatic launch();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Watches edges elapsed+1..30 after the launch edge for done pulses.
    task automatic wait_done(input int elapsed, output int lat, output int ndone,
                             output logic [31:0] res, output logic bsy);
        lat = -1;
        ndone = 0;
        res = '0;
        bsy = 1'bx;
        for (int k = elapsed + 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (bus.done_o === 1'b1) begin
                if (lat < 0) begin
                    lat = k;
                    res = {8'h00, bus.result};
                    bsy = bus.busy;
                end
                ndone++;
            end
        end
    endtask

    task automatic run_check(input string tag, input int m, input int sh, input logic [31:0] exp);
        int lat, nd;
        logic [31:0] res;
        logic bsy;
        drive_ops(m, sh);
        launch();
        check({tag, "_busy_launch"}, {31'b0, bus.busy}, 32'd1);
        wait_done(0, lat, nd, res, bsy);
        check({tag, "_latency"}, lat, NE + 2);
        check({tag, "_ndone"}, nd, 1);
        check({tag, "_busy_at_done"}, {31'b0, bsy}, 32'd0);
        check({tag, "_result"}, res, exp);
    endtask

    initial begin
        int lat, nd, m, sh;
        logic [31:0] res, exp_v;
        logic bsy;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.mode = 2'b00;
        bus.shift = 4'd0;
        bus.window = '0;
        bus.kernel_a = '0;
        bus.kernel_b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done_o}, 32'd0);
        check("rst_result", {8'h00, bus.result}, 32'd0);
        reset = 1'b0;

        // Sobel-x with transpose as second kernel
        pix = '{10, 10, 20, 10, 10, 20, 10, 10, 20};
        ka  = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
        kb  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_check("sobel_m10", 2, 0, 32'h00280028);

        ka = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
        run_check("neg_m00", 0, 0, 32'h00280028);
        run_check("neg_m01", 1, 0, 32'h00000000);

        for (int i = 0; i < NE; i++) begin
            pix[i] = 255; ka[i] = 1; kb[i] = 1;
        end
        run_check("sat_m11", 3, 0, 32'h00FFFFFF);

        // Operand change and re-pulse during RUN are ignored
        for (int i = 0; i < NE; i++) begin
            pix[i] = $urandom_range(0, 255);
            ka[i]  = int'($urandom_range(0, 255)) - 128;
            kb[i]  = int'($urandom_range(0, 255)) - 128;
        end
        exp_v = model(3, 0);
        drive_ops(3, 0);
        launch();
        repeat (2) @(posedge clk);
        #1;
        bus.window = ~bus.window;
        bus.kernel_a = ~bus.kernel_a;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(3, lat, nd, res, bsy);
        check("latch_latency", lat, NE + 2);
        check("latch_ndone", nd, 1);
        check("latch_result", res, exp_v);

        // Mid-run reset abandons the operation
        drive_ops(3, 0);
        launch();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        check("midrst_done", {31'b0, bus.done_o}, 32'd0);
        check("midrst_result", {8'h00, bus.result}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_done(0, lat, nd, res, bsy);
        check("midrst_no_done", nd, 0);
        run_check("after_rst", 3, 0, exp_v);

        // Normalisation shift
        for (int i = 0; i < NE; i++) begin
            pix[i] = 100; ka[i] = 1; kb[i] = 0;
        end
`ifdef NORM_SHIFT_EN
        run_check("shift3", 0, 3, 32'h00700070);
`else
        run_check("shift3", 0, 3, 32'h00FF00FF);
`endif

        // Randomized operations against the reference model
        for (int t = 0; t < 12; t++) begin
            m  = $urandom_range(0, 3);
            sh = $urandom_range(0, 15);
            for (int i = 0; i < NE; i++) begin
                pix[i] = $urandom_range(0, 255);
                ka[i]  = int'($urandom_range(0, 255)) - 128;
                kb[i]  = int'($urandom_range(0, 255)) - 128;
                if (t < 4) begin
                    ka[i] = ka[i] / 16;
                    kb[i] = kb[i] / 16;
                    pix[i] = pix[i] / 8;
                end
            end
            run_check($sformatf("rand%0d_m%0d", t, m), m, sh, model(m, sh));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
